// File: rtl/y86_rf_dbg_ctrl_pkg.sv
// Shared y86 definitions for the register-file debug controller:
// FSM encoding, register count and register index width.
package y86_rf_dbg_ctrl_pkg;

   localparam int unsigned NumRegs = 8;
   localparam int unsigned IdxW    = 4;
   localparam int unsigned DataW   = 32;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StStall  = 2'd1,
      StAccess = 2'd2,
      StResp   = 2'd3
   } dbg_state_e;

endpackage

// File: rtl/y86_rf_dbg_ctrl_if.sv
// Debug-side handshake bundle: request/response plus the pipeline freeze handshake.
interface y86_rf_dbg_ctrl_if;

   logic                                      dbg_req;
   logic                                      dbg_we;
   logic [y86_rf_dbg_ctrl_pkg::IdxW-1:0]      dbg_reg;
   logic [y86_rf_dbg_ctrl_pkg::DataW-1:0]     dbg_wdata;
   logic [y86_rf_dbg_ctrl_pkg::DataW-1:0]     dbg_rdata;
   logic                                      dbg_done;
   logic                                      dbg_err;
   logic                                      stall_req;
   logic                                      stall_ack;

   modport master (
      output dbg_req, dbg_we, dbg_reg, dbg_wdata, stall_ack,
      input  dbg_rdata, dbg_done, dbg_err, stall_req
   );

   modport slave (
      input  dbg_req, dbg_we, dbg_reg, dbg_wdata, stall_ack,
      output dbg_rdata, dbg_done, dbg_err, stall_req
   );

endinterface

// File: rtl/y86_rf_dbg_ctrl.sv
// Debug access port for the y86 register file: freezes the pipeline, then borrows
// the read port A / write port E for one cycle to perform a single read or write.
module y86_rf_dbg_ctrl
   import y86_rf_dbg_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             dbg_req,
   input  logic             dbg_we,
   input  logic [IdxW-1:0]  dbg_reg,
   input  logic [DataW-1:0] dbg_wdata,
   output logic [DataW-1:0] dbg_rdata,
   output logic             dbg_done,
   output logic             dbg_err,
   output logic             stall_req,
   input  logic             stall_ack,
   input  logic [IdxW-1:0]  p_srcA,
   input  logic [IdxW-1:0]  p_dstE,
   input  logic [DataW-1:0] p_valE,
   input  logic             p_writeE,
   output logic [IdxW-1:0]  rf_srcA,
   output logic [IdxW-1:0]  rf_dstE,
   output logic [DataW-1:0] rf_valE,
   output logic             rf_writeE,
   input  logic [DataW-1:0] rf_rvalA
);

   localparam int unsigned     CntW     = $clog2(TIMEOUT + 1);
   localparam logic [CntW-1:0] CntMax   = CntW'(TIMEOUT);
   localparam logic [IdxW-1:0] RegLimit = IdxW'(NumRegs);

   dbg_state_e       state_q, state_d;
   logic             we_q, we_d;
   logic [IdxW-1:0]  reg_q, reg_d;
   logic [DataW-1:0] wdata_q, wdata_d;
   logic [DataW-1:0] rdata_q, rdata_d;
   logic             err_q, err_d;
   logic [CntW-1:0]  cnt_q, cnt_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         we_q    <= 1'b0;
         reg_q   <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         reg_q   <= reg_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      reg_d   = reg_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (dbg_req) begin
               we_d    = dbg_we;
               reg_d   = dbg_reg;
               wdata_d = dbg_wdata;
               cnt_d   = '0;
               // Out-of-range index is rejected without disturbing the pipeline.
               if (dbg_reg < RegLimit) begin
                  err_d   = 1'b0;
                  state_d = StStall;
               end else begin
                  err_d   = 1'b1;
                  state_d = StResp;
               end
            end
         end
         StStall: begin
            if (stall_ack) begin
               state_d = StAccess;
            end else begin
               cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
               if (cnt_d == CntMax) begin
                  err_d   = 1'b1;
                  state_d = StResp;
               end
            end
         end
         StAccess: begin
            state_d = StResp;
            // A colliding pipeline write is dropped and poisons this transaction.
            if (p_writeE) begin
               err_d = 1'b1;
            end else if (!we_q) begin
               rdata_d = rf_rvalA;
            end
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_comb begin
      stall_req = (state_q == StStall) || (state_q == StAccess);
      dbg_done  = (state_q == StResp);
      dbg_err   = (state_q == StResp) && err_q;
      dbg_rdata = rdata_q;
      rf_srcA   = p_srcA;
      rf_dstE   = p_dstE;
      rf_valE   = p_valE;
      rf_writeE = p_writeE;
      if (state_q == StAccess) begin
         rf_srcA   = reg_q;
         rf_dstE   = reg_q;
         rf_valE   = wdata_q;
         rf_writeE = we_q;
      end
   end

endmodule

// File: tb/tb_y86_rf_dbg_ctrl.sv
// Directed bench for y86_rf_dbg_ctrl with a behavioural register file on the rf_* ports.
module tb_y86_rf_dbg_ctrl;

   logic        clk;
   logic        reset;
   logic [3:0]  p_srcA;
   logic [3:0]  p_dstE;
   logic [31:0] p_valE;
   logic        p_writeE;
   logic [3:0]  rf_srcA;
   logic [3:0]  rf_dstE;
   logic [31:0] rf_valE;
   logic        rf_writeE;
   logic [31:0] rf_rvalA;

   y86_rf_dbg_ctrl_if dbg_if ();

   y86_rf_dbg_ctrl #(.TIMEOUT(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .dbg_req   (dbg_if.dbg_req),
      .dbg_we    (dbg_if.dbg_we),
      .dbg_reg   (dbg_if.dbg_reg),
      .dbg_wdata (dbg_if.dbg_wdata),
      .dbg_rdata (dbg_if.dbg_rdata),
      .dbg_done  (dbg_if.dbg_done),
      .dbg_err   (dbg_if.dbg_err),
      .stall_req (dbg_if.stall_req),
      .stall_ack (dbg_if.stall_ack),
      .p_srcA    (p_srcA),
      .p_dstE    (p_dstE),
      .p_valE    (p_valE),
      .p_writeE  (p_writeE),
      .rf_srcA   (rf_srcA),
      .rf_dstE   (rf_dstE),
      .rf_valE   (rf_valE),
      .rf_writeE (rf_writeE),
      .rf_rvalA  (rf_rvalA)
   );

   // Register file model; preload port lets the bench seed contents.
   logic [31:0] mem [16];
   logic        pre_en;
   logic [3:0]  pre_idx;
   logic [31:0] pre_val;
   int          wr_cnt;
   logic [3:0]  last_dst;
   logic [31:0] last_val;

   assign rf_rvalA = mem[rf_srcA];

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 32'h0;
      wr_cnt   = 0;
      last_dst = 4'h0;
      last_val = 32'h0;
   end

   always @(posedge clk) begin
      if (pre_en) begin
         mem[pre_idx] <= pre_val;
      end else if (rf_writeE) begin
         mem[rf_dstE] <= rf_valE;
         wr_cnt       <= wr_cnt + 1;
         last_dst     <= rf_dstE;
         last_val     <= rf_valE;
      end
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp;
   int n_fail;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic idle_inputs();
      dbg_if.dbg_req   = 1'b0;
      dbg_if.dbg_we    = 1'b0;
      dbg_if.dbg_reg   = 4'h0;
      dbg_if.dbg_wdata = 32'h0;
      dbg_if.stall_ack = 1'b0;
      p_srcA   = 4'h0;
      p_dstE   = 4'h0;
      p_valE   = 32'h0;
      p_writeE = 1'b0;
   endtask

   task automatic preload(input logic [3:0] idx, input logic [31:0] val);
      @(negedge clk);
      pre_en  = 1'b1;
      pre_idx = idx;
      pre_val = val;
      @(negedge clk);
      pre_en = 1'b0;
   endtask

   // Bounded wait for dbg_done; returns at the negedge where it was seen.
   task automatic wait_done(input int max_cyc, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < max_cyc && !seen; i++) begin
         @(negedge clk);
         if (dbg_if.dbg_done === 1'b1) seen = 1'b1;
      end
   endtask

   task automatic test_reset();
      reset  = 1'b0;
      pre_en = 1'b0;
      pre_idx = 4'h0;
      pre_val = 32'h0;
      idle_inputs();
      p_srcA = 4'hA;
      #1;
      n_cmp++;
      if ({dbg_if.stall_req, dbg_if.dbg_done, dbg_if.dbg_err} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b want 000",
                  {dbg_if.stall_req, dbg_if.dbg_done, dbg_if.dbg_err});
      end
      n_cmp++;
      if (dbg_if.dbg_rdata !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_rdata: got %h want 00000000", dbg_if.dbg_rdata);
      end
      n_cmp++;
      if (rf_srcA !== 4'hA || rf_writeE !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_pass: got srcA=%h we=%b want srcA=a we=0", rf_srcA, rf_writeE);
      end
      @(negedge clk);
      @(negedge clk);
      reset  = 1'b1;
      p_srcA = 4'h0;
   endtask

   task automatic test_read();
      preload(4'd3, 32'hDEADBEEF);
      dbg_if.dbg_req   = 1'b1;
      dbg_if.dbg_we    = 1'b0;
      dbg_if.dbg_reg   = 4'd3;
      dbg_if.stall_ack = 1'b1;
      @(negedge clk);
      dbg_if.dbg_req = 1'b0;
      n_cmp++;
      if (dbg_if.stall_req !== 1'b1 || dbg_if.dbg_done !== 1'b0) begin
         n_fail++;
         $display("FAIL read_stall: got stall=%b done=%b want 1 0",
                  dbg_if.stall_req, dbg_if.dbg_done);
      end
      @(negedge clk);
      n_cmp++;
      if (rf_srcA !== 4'd3 || dbg_if.stall_req !== 1'b1 || dbg_if.dbg_done !== 1'b0) begin
         n_fail++;
         $display("FAIL read_access: got srcA=%h stall=%b done=%b want 3 1 0",
                  rf_srcA, dbg_if.stall_req, dbg_if.dbg_done);
      end
      @(negedge clk);
      n_cmp++;
      if (dbg_if.dbg_done !== 1'b1 || dbg_if.dbg_err !== 1'b0 || dbg_if.stall_req !== 1'b0) begin
         n_fail++;
         $display("FAIL read_done: got done=%b err=%b stall=%b want 1 0 0",
                  dbg_if.dbg_done, dbg_if.dbg_err, dbg_if.stall_req);
      end
      n_cmp++;
      if (dbg_if.dbg_rdata !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL read_data: got %h want deadbeef", dbg_if.dbg_rdata);
      end
      dbg_if.stall_ack = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (dbg_if.dbg_done !== 1'b0) begin
         n_fail++;
         $display("FAIL read_pulse: got done=%b want 0", dbg_if.dbg_done);
      end
   endtask

   task automatic test_write();
      int wc0;
      bit seen;
      wc0 = wr_cnt;
      @(negedge clk);
      dbg_if.dbg_req   = 1'b1;
      dbg_if.dbg_we    = 1'b1;
      dbg_if.dbg_reg   = 4'd5;
      dbg_if.dbg_wdata = 32'h12345678;
      dbg_if.stall_ack = 1'b0;
      @(negedge clk);
      dbg_if.dbg_req = 1'b0;
      repeat (3) @(negedge clk);
      dbg_if.stall_ack = 1'b1;
      wait_done(6, seen);
      n_cmp++;
      if (!seen || dbg_if.dbg_err !== 1'b0) begin
         n_fail++;
         $display("FAIL write_done: got seen=%0d err=%b want 1 0", seen, dbg_if.dbg_err);
      end
      dbg_if.stall_ack = 1'b0;
      n_cmp++;
      if (wr_cnt - wc0 !== 1 || last_dst !== 4'd5 || last_val !== 32'h12345678) begin
         n_fail++;
         $display("FAIL write_port: got n=%0d dst=%h val=%h want 1 5 12345678",
                  wr_cnt - wc0, last_dst, last_val);
      end
      @(negedge clk);
      dbg_if.dbg_req   = 1'b1;
      dbg_if.dbg_we    = 1'b0;
      dbg_if.dbg_reg   = 4'd5;
      dbg_if.stall_ack = 1'b1;
      @(negedge clk);
      dbg_if.dbg_req = 1'b0;
      wait_done(4, seen);
      dbg_if.stall_ack = 1'b0;
      n_cmp++;
      if (!seen || dbg_if.dbg_rdata !== 32'h12345678) begin
         n_fail++;
         $display("FAIL write_readback: got seen=%0d rdata=%h want 1 12345678",
                  seen, dbg_if.dbg_rdata);
      end
   endtask

   task automatic test_bad_index();
      int wc0;
      bit seen;
      bit stall_seen;
      logic err;
      wc0 = wr_cnt;
      seen = 1'b0;
      stall_seen = 1'b0;
      err = 1'b0;
      @(negedge clk);
      dbg_if.dbg_req   = 1'b1;
      dbg_if.dbg_we    = 1'b1;
      dbg_if.dbg_reg   = 4'd9;
      dbg_if.dbg_wdata = 32'hBAD0BAD0;
      dbg_if.stall_ack = 1'b1;
      for (int i = 0; i < 2 && !seen; i++) begin
         @(negedge clk);
         dbg_if.dbg_req = 1'b0;
         if (dbg_if.stall_req === 1'b1) stall_seen = 1'b1;
         if (dbg_if.dbg_done === 1'b1) begin
            seen = 1'b1;
            err  = dbg_if.dbg_err;
         end
      end
      dbg_if.stall_ack = 1'b0;
      @(negedge clk);
      if (dbg_if.stall_req === 1'b1) stall_seen = 1'b1;
      n_cmp++;
      if (!seen || err !== 1'b1) begin
         n_fail++;
         $display("FAIL badidx_done: got seen=%0d err=%b want 1 1", seen, err);
      end
      n_cmp++;
      if (stall_seen || wr_cnt != wc0) begin
         n_fail++;
         $display("FAIL badidx_quiet: got stall=%0d writes=%0d want 0 0",
                  stall_seen, wr_cnt - wc0);
      end
      n_cmp++;
      if (dbg_if.dbg_rdata !== 32'h12345678) begin
         n_fail++;
         $display("FAIL badidx_rdata: got %h want 12345678", dbg_if.dbg_rdata);
      end
   endtask

   task automatic test_timeout();
      int wc0;
      int stall_cyc;
      bit seen;
      logic err;
      logic stall_at_done;
      wc0 = wr_cnt;
      stall_cyc = 0;
      seen = 1'b0;
      err = 1'b0;
      stall_at_done = 1'b1;
      @(negedge clk);
      dbg_if.dbg_req   = 1'b1;
      dbg_if.dbg_we    = 1'b1;
      dbg_if.dbg_reg   = 4'd1;
      dbg_if.dbg_wdata = 32'h0BADF00D;
      dbg_if.stall_ack = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         dbg_if.dbg_req = 1'b0;
         if (dbg_if.stall_req === 1'b1) stall_cyc++;
         if (dbg_if.dbg_done === 1'b1) begin
            seen          = 1'b1;
            err           = dbg_if.dbg_err;
            stall_at_done = dbg_if.stall_req;
         end
      end
      n_cmp++;
      if (!seen || err !== 1'b1 || stall_at_done !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_done: got seen=%0d err=%b stall=%b want 1 1 0",
                  seen, err, stall_at_done);
      end
      n_cmp++;
      if (stall_cyc != 16) begin
         n_fail++;
         $display("FAIL timeout_len: got %0d stall cycles want 16", stall_cyc);
      end
      n_cmp++;
      if (wr_cnt != wc0 || dbg_if.dbg_rdata !== 32'h12345678) begin
         n_fail++;
         $display("FAIL timeout_side: got writes=%0d rdata=%h want 0 12345678",
                  wr_cnt - wc0, dbg_if.dbg_rdata);
      end
   endtask

   task automatic test_collision();
      preload(4'd2, 32'h22222222);
      dbg_if.dbg_req   = 1'b1;
      dbg_if.dbg_we    = 1'b1;
      dbg_if.dbg_reg   = 4'd6;
      dbg_if.dbg_wdata = 32'hCAFEF00D;
      dbg_if.stall_ack = 1'b1;
      @(negedge clk);
      dbg_if.dbg_req = 1'b0;
      @(negedge clk);
      p_writeE = 1'b1;
      p_dstE   = 4'd2;
      p_valE   = 32'h11111111;
      #1;
      n_cmp++;
      if (rf_writeE !== 1'b1 || rf_dstE !== 4'd6 || rf_valE !== 32'hCAFEF00D) begin
         n_fail++;
         $display("FAIL coll_port: got we=%b dst=%h val=%h want 1 6 cafef00d",
                  rf_writeE, rf_dstE, rf_valE);
      end
      @(negedge clk);
      p_writeE = 1'b0;
      dbg_if.stall_ack = 1'b0;
      n_cmp++;
      if (dbg_if.dbg_done !== 1'b1 || dbg_if.dbg_err !== 1'b1) begin
         n_fail++;
         $display("FAIL coll_err: got done=%b err=%b want 1 1", dbg_if.dbg_done, dbg_if.dbg_err);
      end
      n_cmp++;
      if (mem[6] !== 32'hCAFEF00D || mem[2] !== 32'h22222222) begin
         n_fail++;
         $display("FAIL coll_mem: got r6=%h r2=%h want cafef00d 22222222", mem[6], mem[2]);
      end
   endtask

   task automatic test_reset_in_stall();
      int wc0;
      bit done_seen;
      bit stall_seen;
      wc0 = wr_cnt;
      done_seen = 1'b0;
      stall_seen = 1'b0;
      @(negedge clk);
      p_srcA = 4'd5;
      dbg_if.dbg_req   = 1'b1;
      dbg_if.dbg_we    = 1'b1;
      dbg_if.dbg_reg   = 4'd4;
      dbg_if.dbg_wdata = 32'hFFFF0000;
      dbg_if.stall_ack = 1'b0;
      @(negedge clk);
      dbg_if.dbg_req = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      #1;
      n_cmp++;
      if ({dbg_if.stall_req, dbg_if.dbg_done, dbg_if.dbg_err} !== 3'b000 ||
          dbg_if.dbg_rdata !== 32'h0) begin
         n_fail++;
         $display("FAIL rststall_out: got ctl=%b rdata=%h want 000 00000000",
                  {dbg_if.stall_req, dbg_if.dbg_done, dbg_if.dbg_err}, dbg_if.dbg_rdata);
      end
      n_cmp++;
      if (rf_srcA !== 4'd5 || rf_writeE !== 1'b0) begin
         n_fail++;
         $display("FAIL rststall_pass: got srcA=%h we=%b want 5 0", rf_srcA, rf_writeE);
      end
      @(negedge clk);
      reset = 1'b1;
      dbg_if.stall_ack = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (dbg_if.dbg_done === 1'b1) done_seen = 1'b1;
         if (dbg_if.stall_req === 1'b1) stall_seen = 1'b1;
      end
      dbg_if.stall_ack = 1'b0;
      n_cmp++;
      if (done_seen || stall_seen || wr_cnt != wc0) begin
         n_fail++;
         $display("FAIL rststall_abort: got done=%0d stall=%0d writes=%0d want 0 0 0",
                  done_seen, stall_seen, wr_cnt - wc0);
      end
      p_srcA   = 4'd7;
      p_dstE   = 4'd3;
      p_valE   = 32'hA5A5A5A5;
      p_writeE = 1'b1;
      #1;
      n_cmp++;
      if (rf_srcA !== 4'd7 || rf_dstE !== 4'd3 || rf_valE !== 32'hA5A5A5A5 || rf_writeE !== 1'b1)
      begin
         n_fail++;
         $display("FAIL idle_pass: got %h %h %h %b want 7 3 a5a5a5a5 1",
                  rf_srcA, rf_dstE, rf_valE, rf_writeE);
      end
      p_writeE = 1'b0;
      p_srcA   = 4'd0;
      p_dstE   = 4'd0;
      p_valE   = 32'h0;
   endtask

   task automatic test_back_to_back();
      int n_done;
      int first_at;
      int second_at;
      n_done = 0;
      first_at = -1;
      second_at = -1;
      @(negedge clk);
      dbg_if.dbg_req   = 1'b1;
      dbg_if.dbg_we    = 1'b0;
      dbg_if.dbg_reg   = 4'd3;
      dbg_if.stall_ack = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         @(negedge clk);
         if (dbg_if.dbg_done === 1'b1) begin
            n_done++;
            if (first_at < 0) first_at = i;
            else second_at = i;
         end
      end
      dbg_if.dbg_req   = 1'b0;
      dbg_if.stall_ack = 1'b0;
      n_cmp++;
      if (n_done != 2 || first_at != 3 || second_at != 7) begin
         n_fail++;
         $display("FAIL b2b_timing: got n=%0d at %0d,%0d want 2 at 3,7",
                  n_done, first_at, second_at);
      end
      n_cmp++;
      if (dbg_if.dbg_rdata !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL b2b_data: got %h want deadbeef", dbg_if.dbg_rdata);
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      test_reset();
      test_read();
      test_write();
      test_bad_index();
      test_timeout();
      test_collision();
      test_reset_in_stall();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/y86_rf_dbg_ctrl.md
Y86_RF_DBG_CTRL -- requirements
Module: y86_rf_dbg_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, max cycles waiting for stall_ack before abort.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- dbg_req  in  1  debug access request, level.
- dbg_we  in  1  1 = write, 0 = read.
- dbg_reg  in  4  register index.
- dbg_wdata  in  32  write data.
- dbg_rdata  out  32  read data, registered.
- dbg_done  out  1  one-cycle completion pulse.
- dbg_err  out  1  error flag, valid with dbg_done.
- stall_req  out  1  request pipeline freeze.
- stall_ack  in  1  pipeline frozen, no writeback in flight.
- p_srcA  in  4  pipeline read index A.
- p_dstE  in  4  pipeline E write index.
- p_valE  in  32  pipeline E write data.
- p_writeE  in  1  pipeline E write enable.
- rf_srcA  out  4  to register file srcA.
- rf_dstE  out  4  to register file dstE.
- rf_valE  out  32  to register file valE.
- rf_writeE  out  1  to register file writeE.
- rf_rvalA  in  32  from register file port A read data.

Function
REQ-003 SHALL implement FSM states IDLE, STALL, ACCESS, RESP.
REQ-004 IDLE: dbg_req=1 SHALL latch dbg_we, dbg_reg, dbg_wdata; dbg_reg<=7 -> STALL; dbg_reg>7 -> RESP with error, no stall.
REQ-005 STALL SHALL assert stall_req and count cycles; stall_ack=1 -> ACCESS; count reaching TIMEOUT without ack -> RESP with error.
REQ-006 ACCESS SHALL last exactly one cycle, with stall_req held at 1.
REQ-007 ACCESS, read: rf_srcA SHALL equal latched index; rf_rvalA SHALL be captured into dbg_rdata at the closing edge.
REQ-008 ACCESS, write: rf_dstE/rf_valE SHALL equal latched index/data and rf_writeE SHALL be 1, for exactly that one cycle.
REQ-009 ACCESS: a pipeline write in the same cycle (p_writeE=1) SHALL be dropped and SHALL set the error for this transaction.
REQ-010 In all states other than ACCESS, rf_* outputs SHALL pass p_* inputs through combinationally, unchanged.
REQ-011 RESP SHALL pulse dbg_done for one cycle with dbg_err valid, SHALL deassert stall_req, then -> IDLE.
REQ-012 dbg_req SHALL be ignored outside IDLE; a request still held after done SHALL start a new transaction from IDLE, minimum 1 idle cycle between transactions.
REQ-013 Latency, read/write with immediate ack: req sampled at edge N -> done high in cycle N+3.
REQ-014 dbg_rdata SHALL hold its value until the next successful read; errors and writes SHALL leave it unchanged.
REQ-015 The timeout counter SHALL be wide enough for TIMEOUT, SHALL saturate, and SHALL clear on entry to STALL.

Reset
REQ-016 reset=0 SHALL asynchronously force: state IDLE, stall_req=0, dbg_done=0, dbg_err=0, dbg_rdata=0, counter=0, latched fields=0.
REQ-017 rf_* SHALL pass through p_* during reset.
REQ-018 Reset mid-transaction SHALL abort it: no done pulse, no register write after reset release.

Structure
REQ-019 A shared y86 package SHALL hold the FSM state encoding, register count (8), and index width (4).
REQ-020 The block SHALL be flat, one module; no sub-module.

Verification
REQ-021 Read: reg 3 holds 0xDEADBEEF, req read reg 3, ack immediate -> done in cycle N+3, rdata=0xDEADBEEF, err=0.
REQ-022 Write: req write reg 5 = 0x12345678, ack after 4 cycles -> exactly one writeE pulse to dstE=5; reg 5 reads back 0x12345678.
REQ-023 Bad index: req reg 9 -> stall_req never rises, done+err within 2 cycles, no rf write.
REQ-024 Timeout: stall_ack held 0 -> done+err after TIMEOUT(16) STALL cycles, stall_req drops, no rf write.
REQ-025 Collision: p_writeE=1, p_dstE=2 during write ACCESS -> debug data written, err=1.
REQ-026 Reset asserted in STALL -> all outputs return to reset values; no done pulse; passthrough resumes.
